// File: rtl/asic_ram_arbiter.sv
// asic_ram_arbiter: shares the Plus ASIC RAM between video, CPU and DMA using fixed
// priority, with DMA promoted to top priority after DMA_MAX_WAIT consecutive denials.
module asic_ram_arbiter #(
  parameter int AW = 14,
  parameter int DW = 8,
  parameter int DMA_MAX_WAIT = 8
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          plus_enable,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  output logic          vid_rvalid,
  output logic [DW-1:0] vid_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  output logic          dma_ack,
  output logic          dma_rvalid,
  output logic [DW-1:0] dma_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  output logic          ram_wr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_q,
  output logic          starve_evt
);
  // Agent index: 0 = video, 1 = CPU, 2 = DMA
  logic [2:0] ack_q, ack_d, rvalid_q, rvalid_d, el, gnt;
  logic [7:0] wait_q, wait_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic [2:0][DW-1:0] hold_q, hold_d;
  logic rd_q, rd_d, wr_q, wr_d, starve_q, starve_d, promote;

  always_comb begin
    el = {dma_req, cpu_req, vid_req} & {3{plus_enable}} & ~ack_q;
    promote = (wait_q == 8'(DMA_MAX_WAIT)) && el[2];
    gnt = promote ? 3'b100 : el[0] ? 3'b001 : el[1] ? 3'b010 : el[2] ? 3'b100 : 3'b000;
    wait_d = (!plus_enable || !dma_req || gnt[2]) ? 8'd0 :
             (el[2] && wait_q < 8'(DMA_MAX_WAIT)) ? wait_q + 8'd1 : wait_q;
    ack_d = gnt;
    addr_d = gnt[0] ? vid_addr : gnt[1] ? cpu_addr : gnt[2] ? dma_addr : addr_q;
    wr_d = gnt[1] & cpu_we;
    rd_d = (|gnt) & ~wr_d;
    din_d = wr_d ? cpu_wdata : din_q;
    starve_d = promote;
    rvalid_d = ack_q & {3{rd_q}};
    for (int i = 0; i < 3; i++) hold_d[i] = rvalid_q[i] ? ram_q : hold_q[i];
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ack_q    <= '0;
      rvalid_q <= '0;
      wait_q   <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      hold_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      starve_q <= 1'b0;
    end else begin
      ack_q    <= ack_d;
      rvalid_q <= rvalid_d;
      wait_q   <= wait_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      hold_q   <= hold_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      starve_q <= starve_d;
    end
  end

  assign {dma_ack, cpu_ack, vid_ack} = ack_q;
  assign {dma_rvalid, cpu_rvalid, vid_rvalid} = rvalid_q;
  // Read data passes straight from the RAM on the return cycle, otherwise holds
  assign vid_rdata = rvalid_q[0] ? ram_q : hold_q[0];
  assign cpu_rdata = rvalid_q[1] ? ram_q : hold_q[1];
  assign dma_rdata = rvalid_q[2] ? ram_q : hold_q[2];
  assign ram_addr = addr_q;
  assign ram_din = din_q;
  assign ram_rd = rd_q;
  assign ram_wr = wr_q;
  assign starve_evt = starve_q;
endmodule

// File: tb/tb_asic_ram_arbiter.sv
// tb_asic_ram_arbiter: randomized and directed scoreboard bench for asic_ram_arbiter
// with a cycle-level reference model and a behavioural synchronous RAM.
module tb_asic_ram_arbiter;
  localparam int MAXW = 8;

  typedef struct packed {
    int         cyc;
    logic [2:0] who;
    logic [13:0] addr;
    logic       rd;
    logic       wr;
    logic [7:0] din;
    logic       st;
  } ack_t;
  typedef struct packed {
    int         cyc;
    logic [2:0] who;
    logic [7:0] data;
  } rv_t;

  logic clk_sys = 0, reset_n = 0, plus_enable = 0;
  logic vid_req = 0, cpu_req = 0, cpu_we = 0, dma_req = 0;
  logic [13:0] vid_addr = 0, cpu_addr = 0, dma_addr = 0;
  logic [7:0] cpu_wdata = 0;
  logic vid_ack, vid_rvalid, cpu_ack, cpu_rvalid, dma_ack, dma_rvalid;
  logic [7:0] vid_rdata, cpu_rdata, dma_rdata, ram_din, ram_q;
  logic [13:0] ram_addr;
  logic ram_rd, ram_wr, starve_evt;

  int checks = 0, failures = 0, cyc = 0;
  ack_t aq[$];
  rv_t rq[$];
  int ack_log[$];
  logic [7:0] mem [0:16383];
  logic [7:0] ref_mem [0:16383];
  int exp_seq [9] = '{0, 1, 0, 1, 0, 1, 0, 1, 6};

  asic_ram_arbiter #(.AW(14), .DW(8), .DMA_MAX_WAIT(MAXW)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .plus_enable(plus_enable),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_ack(dma_ack), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .ram_addr(ram_addr), .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_din(ram_din), .ram_q(ram_q),
    .starve_evt(starve_evt)
  );

  always #5 clk_sys = ~clk_sys;

  logic [54:0] outs;
  assign outs = {vid_ack, cpu_ack, dma_ack, vid_rvalid, cpu_rvalid, dma_rvalid, ram_rd, ram_wr,
                 starve_evt, ram_addr, ram_din, vid_rdata, cpu_rdata, dma_rdata};

  always @(posedge clk_sys) begin
    if (ram_wr) mem[ram_addr] <= ram_din;
    if (ram_rd) ram_q <= mem[ram_addr];
  end

  // Reference model: the priority order is rotated when DMA has waited too long
  logic [2:0] m_ack = 0, m_el;
  int m_wait = 0, m_g;
  logic m_prom;
  ack_t m_e;
  rv_t m_r;
  always @(posedge clk_sys) begin
    if (!reset_n) begin
      m_ack = 0;
      m_wait = 0;
      aq.delete();
      rq.delete();
    end else begin
      m_el = {dma_req, cpu_req, vid_req} & {3{plus_enable}} & ~m_ack;
      m_prom = (m_wait >= MAXW) && m_el[2];
      m_g = -1;
      for (int k = 0; k < 3; k++) begin
        int a;
        a = m_prom ? (k + 2) % 3 : k;
        if (m_g < 0 && m_el[a]) m_g = a;
      end
      if (!plus_enable || !dma_req || m_g == 2) m_wait = 0;
      else if (m_el[2] && m_wait < MAXW) m_wait++;
      m_ack = 0;
      if (m_g >= 0) begin
        m_ack[m_g] = 1'b1;
        m_e.cyc = cyc + 1;
        m_e.who = 3'b001 << m_g;
        m_e.addr = (m_g == 0) ? vid_addr : (m_g == 1) ? cpu_addr : dma_addr;
        m_e.wr = (m_g == 1) && cpu_we;
        m_e.rd = !m_e.wr;
        m_e.din = m_e.wr ? cpu_wdata : 8'h00;
        m_e.st = m_prom;
        aq.push_back(m_e);
        if (m_e.wr) ref_mem[m_e.addr] = cpu_wdata;
        else begin
          m_r.cyc = cyc + 2;
          m_r.who = m_e.who;
          m_r.data = ref_mem[m_e.addr];
          rq.push_back(m_r);
        end
      end
    end
    cyc++;
  end

  // Monitor: pops expectations whenever the DUT presents an ack or rvalid
  logic [2:0] mon_acks, mon_rvs;
  logic [7:0] mon_last [3];
  logic [7:0] mon_rd;
  logic [44:0] mon_exp_a, mon_act_a;
  logic [42:0] mon_exp_r, mon_act_r;
  ack_t mon_e;
  rv_t mon_r;
  always @(negedge clk_sys) begin
    if (!reset_n) begin
      mon_last = '{8'h00, 8'h00, 8'h00};
      checks++;
      if (outs != 0) begin failures++; $display("FAIL reset_outputs got=%h want=0", outs); end
    end else begin
      mon_acks = {dma_ack, cpu_ack, vid_ack};
      mon_rvs = {dma_rvalid, cpu_rvalid, vid_rvalid};
      while (aq.size() > 0 && aq[0].cyc < cyc) begin
        checks++; failures++;
        $display("FAIL ack_missing cyc=%0d got=none want_who=%b", aq[0].cyc, aq[0].who);
        void'(aq.pop_front());
      end
      while (rq.size() > 0 && rq[0].cyc < cyc) begin
        checks++; failures++;
        $display("FAIL rvalid_missing cyc=%0d got=none want_who=%b", rq[0].cyc, rq[0].who);
        void'(rq.pop_front());
      end
      if (mon_acks != 0 || ram_rd || ram_wr || starve_evt) begin
        checks++;
        mon_act_a = {16'(cyc), mon_acks, ram_addr, ram_rd, ram_wr, ram_wr ? ram_din : 8'h00, starve_evt};
        if (aq.size() == 0) begin
          failures++; $display("FAIL ack_unexpected cyc=%0d got=%h want=none", cyc, mon_act_a);
        end else begin
          mon_e = aq.pop_front();
          mon_exp_a = {16'(mon_e.cyc), mon_e.who, mon_e.addr, mon_e.rd, mon_e.wr, mon_e.din, mon_e.st};
          if (mon_act_a != mon_exp_a) begin
            failures++; $display("FAIL ack_grant cyc=%0d got=%h want=%h", cyc, mon_act_a, mon_exp_a);
          end
        end
        ack_log.push_back((mon_acks[0] ? 0 : mon_acks[1] ? 1 : mon_acks[2] ? 2 : 3) + (starve_evt ? 4 : 0));
      end
      if (mon_rvs != 0) begin
        checks++;
        mon_rd = mon_rvs[0] ? vid_rdata : mon_rvs[1] ? cpu_rdata : dma_rdata;
        mon_act_r = {16'(cyc), mon_rvs, mon_rd};
        if (rq.size() == 0) begin
          failures++; $display("FAIL rvalid_unexpected cyc=%0d got=%h want=none", cyc, mon_act_r);
        end else begin
          mon_r = rq.pop_front();
          mon_exp_r = {16'(mon_r.cyc), mon_r.who, mon_r.data};
          if (mon_act_r != mon_exp_r) begin
            failures++; $display("FAIL rvalid_data cyc=%0d got=%h want=%h", cyc, mon_act_r, mon_exp_r);
          end
          for (int i = 0; i < 3; i++) if (mon_r.who[i]) mon_last[i] = mon_r.data;
        end
      end
      checks++;
      if ({dma_rdata, cpu_rdata, vid_rdata} != {mon_last[2], mon_last[1], mon_last[0]}) begin
        failures++;
        $display("FAIL rdata_hold cyc=%0d got=%h want=%h", cyc, {dma_rdata, cpu_rdata, vid_rdata},
                 {mon_last[2], mon_last[1], mon_last[0]});
      end
      checks++;
      if (!$onehot0(mon_acks) || !$onehot0(mon_rvs) || (ram_rd && ram_wr)) begin
        failures++; $display("FAIL exclusivity cyc=%0d got=%b%b%b%b want=onehot0", cyc, mon_acks, mon_rvs, ram_rd, ram_wr);
      end
    end
  end

  task automatic step();
    @(posedge clk_sys);
    #2;
  endtask

  task automatic idle(input int n);
    vid_req = 0; cpu_req = 0; dma_req = 0;
    repeat (n) step();
  endtask

  task automatic cpu_access(input logic we, input logic [13:0] a, input logic [7:0] d);
    int n;
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    n = 0;
    do begin step(); n++; end while (!cpu_ack && n < 20);
    checks++;
    if (!cpu_ack) begin failures++; $display("FAIL cpu_ack_timeout got=0 want=1"); end
    cpu_req = 0;
    repeat (3) step();
  endtask

  task automatic check_seq(input string nm);
    int bad;
    bad = -1;
    for (int i = 0; i < 9; i++)
      if (bad < 0 && (i >= ack_log.size() || ack_log[i] != exp_seq[i])) bad = i;
    checks++;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s idx=%0d got=%0d want=%0d", nm, bad, (bad < ack_log.size()) ? ack_log[bad] : -1, exp_seq[bad]);
    end
  endtask

  function automatic logic [13:0] raddr();
    return ($urandom_range(0, 3) == 0) ? 14'h3FFF : 14'($urandom_range(0, 15));
  endfunction

  initial begin
    int n;
    for (int i = 0; i < 16384; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[14'h2420] = 8'h5A;
    ref_mem[14'h2420] = 8'h5A;
    repeat (3) step();
    reset_n = 1;
    plus_enable = 1;
    idle(2);

    cpu_access(1'b0, 14'h2420, 8'h00);
    cpu_access(1'b1, 14'h0000, 8'hC3);
    cpu_access(1'b0, 14'h0000, 8'h00);

    ack_log.delete();
    vid_req = 1; vid_addr = 14'h0005;
    repeat (6) step();
    idle(3);
    checks++;
    if (ack_log.size() != 3 || ack_log[0] != 0 || ack_log[1] != 0 || ack_log[2] != 0) begin
      failures++; $display("FAIL vid_back_to_back got=%0d acks want=3 video acks", ack_log.size());
    end

    idle(4);
    ack_log.delete();
    vid_req = 1; cpu_req = 1; dma_req = 1; cpu_we = 0;
    vid_addr = 14'h0010; cpu_addr = 14'h0011; dma_addr = 14'h3FFF;
    repeat (20) step();
    idle(4);
    check_seq("contention_order");

    dma_req = 1; dma_addr = 14'h0003;
    n = 0;
    do begin step(); n++; end while (!dma_ack && n < 20);
    checks++;
    if (!dma_ack) begin failures++; $display("FAIL dma_ack_timeout got=0 want=1"); end
    reset_n = 0;
    aq.delete(); rq.delete();
    dma_req = 0;
    repeat (2) step();
    reset_n = 1;
    repeat (3) begin
      step();
      checks++;
      if (outs != 0) begin failures++; $display("FAIL post_reset_idle got=%h want=0", outs); end
    end

    idle(2);
    vid_req = 1; cpu_req = 1; dma_req = 1; cpu_we = 0;
    repeat (5) step();
    plus_enable = 0;
    repeat (10) step();
    ack_log.delete();
    plus_enable = 1;
    repeat (12) step();
    idle(4);
    check_seq("reenable_order");

    for (int c = 0; c < 3000; c++) begin
      step();
      if (vid_req && vid_ack) vid_req = 0;
      if (cpu_req && cpu_ack) cpu_req = 0;
      if (dma_req && dma_ack) dma_req = 0;
      if (!vid_req && $urandom_range(0, 99) < 40) begin vid_req = 1; vid_addr = raddr(); end
      if (!cpu_req && $urandom_range(0, 99) < 40) begin
        cpu_req = 1; cpu_addr = raddr(); cpu_we = 1'($urandom_range(0, 1)); cpu_wdata = 8'($urandom);
      end
      if (!dma_req && $urandom_range(0, 99) < 40) begin dma_req = 1; dma_addr = raddr(); end
      plus_enable = ($urandom_range(0, 19) != 0);
    end
    plus_enable = 1;
    idle(10);
    checks++;
    if (aq.size() != 0 || rq.size() != 0) begin
      failures++; $display("FAIL pending_expectations got=%0d want=0", aq.size() + rq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/asic_ram_arbiter.md
# asic_ram_arbiter

Shares the single-port 16 KB ASIC register/sprite RAM between the three Plus-mode agents that touch it: the video sprite fetcher, the CPU page window (&4000–&7FFF), and the DMA/audio sequencer. It sits between those agents and the ASIC RAM port (14-bit address, 8-bit data, synchronous read). Each cycle it grants at most one access, using fixed priority with an anti-starvation promotion for DMA.

## Interface
Parameters:
- AW, 14, RAM address width
- DW, 8, RAM data width
- DMA_MAX_WAIT, 8, consecutive denied DMA cycles before DMA is promoted to top priority (range 1–255)

Ports:
- clk_sys  in  1  system clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- plus_enable  in  1  arbiter enable (plus_mode & use_asic)
- vid_req  in  1  video read request, held until ack
- vid_addr  in  AW  video read address
- vid_ack  out  1  one-cycle grant pulse
- vid_rvalid  out  1  vid_rdata valid
- vid_rdata  out  DW  read data
- cpu_req  in  1  CPU request, held until ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address (page offset)
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  grant pulse
- cpu_rvalid  out  1  cpu_rdata valid (reads only)
- cpu_rdata  out  DW  read data
- dma_req  in  1  DMA read request, held until ack
- dma_addr  in  AW  DMA read address
- dma_ack  out  1  grant pulse
- dma_rvalid  out  1  dma_rdata valid
- dma_rdata  out  DW  read data
- ram_addr  out  AW  RAM address
- ram_rd  out  1  RAM read strobe
- ram_wr  out  1  RAM write strobe
- ram_din  out  DW  RAM write data
- ram_q  in  DW  RAM read data, valid the cycle after ram_rd
- starve_evt  out  1  one-cycle pulse when DMA promotion fires

## Operation
- Eligibility: requester X is eligible in cycle N when X_req = 1, plus_enable = 1, and X_ack = 0 in cycle N. Masking the ack cycle prevents double-granting a request whose ack is still in flight.
- Default priority: video > CPU > DMA.
- Promotion: when dma_wait = DMA_MAX_WAIT and DMA is eligible, the order becomes DMA > video > CPU for that decision. starve_evt pulses in the ack cycle of that grant.
- dma_wait counter:
  - 8-bit, saturates at DMA_MAX_WAIT.
  - Increments each cycle DMA is eligible and not granted.
  - Clears on DMA grant, when dma_req = 0, or when plus_enable = 0.
- Grant in cycle N, registered at the end of N. In cycle N+1:
  - X_ack = 1.
  - ram_addr = X_addr sampled in N.
  - ram_rd = !write, ram_wr = write (CPU only; video and DMA are read-only).
  - ram_din = cpu_wdata sampled in N.
- Read return: in cycle N+2, X_rvalid = 1 and X_rdata = ram_q. rdata buses hold their last value when rvalid = 0.
- CPU writes produce no rvalid.
- Throughput: one grant per cycle in total. A single requester can get at most one grant every 2 cycles (ack-mask rule).
- plus_enable = 0: no new grants and dma_wait clears. An access already in flight (ack/ram strobe, rvalid) completes normally.

## Timing
- Reset (reset_n = 0, asynchronous):
  - All acks, rvalids, ram_rd, ram_wr, and starve_evt go to 0.
  - ram_addr, ram_din, and all rdata go to 0.
  - dma_wait goes to 0.
  - In-flight reads are discarded; no rvalid appears after reset release.
- Latency: request to ack is 1 cycle when uncontended. Ack to rvalid is 1 cycle. Request to data is 2 cycles.
- ram_rd and ram_wr are never both 1. At most one of the three acks is high per cycle, and at most one of the three rvalids is high per cycle.
- Simultaneous requests: resolved by the current priority order. Losers keep their req high and are reconsidered next cycle.
- A requester dropping req before its ack is a protocol violation; the arbiter ignores the request in any cycle where req = 0.
- Address 14'h3FFF is a normal access; there is no wrap logic, because addresses come from the requesters.

## Test plan
- Uncontended CPU read: cpu_req=1, cpu_addr=14'h2420, ram_q=8'h5A → cpu_ack at +1 with ram_addr=14'h2420 and ram_rd=1; cpu_rvalid=1 and cpu_rdata=8'h5A at +2.
- CPU write: cpu_we=1, cpu_addr=14'h0000, cpu_wdata=8'hC3 → ram_wr=1, ram_din=8'hC3 at +1; no cpu_rvalid ever.
- Three-way contention (all reqs held): grants arrive in the order video, CPU, video, CPU, … while DMA is denied. After 8 denied cycles, dma_ack fires with starve_evt=1, then dma_wait reads 0.
- Back-to-back same requester: vid_req held high for 6 cycles with no other requests → vid_ack on alternate cycles (3 acks), with matching rvalids.
- Reset mid-read: assert reset_n=0 in the ack cycle of a DMA read → dma_rvalid never asserts. After release, all outputs are 0 until a new request.
- plus_enable=0 with all reqs high for 10 cycles → no acks and dma_wait=0. Re-enable → video is granted first.
